// File: rtl/pic_init_sequencer.sv
// rtl/pic_init_sequencer.sv - programs the master/slave i8259 pair (ICW1-4 + OCW1) and arbitrates the shared PIC I/O bus
module pic_init_sequencer #(
  parameter logic [7:0]  MAS_BASE   = 8'h08,
  parameter logic [7:0]  SLA_BASE   = 8'h70,
  parameter logic [7:0]  MAS_MASK   = 8'hB8,
  parameter logic [7:0]  SLA_MASK   = 8'hBD,
  parameter int unsigned GAP        = 1,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       cpu_address,
  input  logic       cpu_read,
  input  logic       cpu_write,
  input  logic [7:0] cpu_writedata,
  input  logic       cpu_master_cs,
  input  logic       cpu_slave_cs,
  output logic       cpu_waitrequest,
  output logic       pic_address,
  output logic       pic_read,
  output logic       pic_write,
  output logic [7:0] pic_writedata,
  output logic       pic_master_cs,
  output logic       pic_slave_cs
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_WRITE, ST_GAP} state_t;

  localparam int unsigned GAP_M1   = (GAP == 0) ? 0 : GAP - 1;
  localparam logic [3:0]  GAP_LOAD = GAP_M1[3:0];
  localparam bit          HAS_GAP  = (GAP != 0);
  localparam logic [3:0]  LAST_IDX = 4'd9;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       pending_q, pending_d;
  logic       done_q, done_d;

  logic       tbl_addr;
  logic       tbl_master;
  logic [7:0] tbl_data;

  // Entries 0..4 program the master, 5..9 the slave; ICW1 goes to the even port.
  always_comb begin
    tbl_master = (idx_q < 4'd5);
    tbl_addr   = !((idx_q == 4'd0) || (idx_q == 4'd5));
    case (idx_q)
      4'd0:    tbl_data = 8'h11;
      4'd1:    tbl_data = MAS_BASE & 8'hF8;
      4'd2:    tbl_data = 8'h04;
      4'd3:    tbl_data = 8'h01;
      4'd4:    tbl_data = MAS_MASK;
      4'd5:    tbl_data = 8'h11;
      4'd6:    tbl_data = SLA_BASE & 8'hF8;
      4'd7:    tbl_data = 8'h02;
      4'd8:    tbl_data = 8'h01;
      4'd9:    tbl_data = SLA_MASK;
      default: tbl_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      gap_cnt_q <= 4'd0;
      pending_q <= AUTO_START;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_cnt_q <= gap_cnt_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_cnt_d = gap_cnt_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start || pending_q) begin
          state_d   = ST_ARB;
          pending_d = 1'b0;
          idx_d     = 4'd0;
        end
      end
      ST_ARB: begin
        if (start) pending_d = 1'b1;
        // A CPU access already on the bus is allowed to finish before we take it.
        if (!(cpu_read || cpu_write)) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (start) pending_d = 1'b1;
        if (HAS_GAP) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (start) pending_d = 1'b1;
        if (gap_cnt_q == 4'd0) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WRITE;
            idx_d   = idx_q + 4'd1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy            = (state_q == ST_WRITE) || (state_q == ST_GAP);
    done            = done_q;
    cpu_waitrequest = busy && (cpu_read || cpu_write);
    pic_address     = 1'b0;
    pic_read        = 1'b0;
    pic_write       = 1'b0;
    pic_writedata   = 8'h00;
    pic_master_cs   = 1'b0;
    pic_slave_cs    = 1'b0;
    case (state_q)
      ST_IDLE, ST_ARB: begin
        pic_address   = cpu_address;
        pic_read      = cpu_read;
        pic_write     = cpu_write;
        pic_writedata = cpu_writedata;
        pic_master_cs = cpu_master_cs;
        pic_slave_cs  = cpu_slave_cs;
      end
      ST_WRITE: begin
        pic_address   = tbl_addr;
        pic_write     = 1'b1;
        pic_writedata = tbl_data;
        pic_master_cs = tbl_master;
        pic_slave_cs  = !tbl_master;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pic_init_sequencer.sv
// tb/tb_pic_init_sequencer.sv - directed self-checking bench for pic_init_sequencer
module tb_pic_init_sequencer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  // dut_a: AUTO_START=1 GAP=1; dut_b: AUTO_START=0 GAP=1; dut_c: AUTO_START=0 GAP=0
  logic       a_start, a_busy, a_done, a_cpu_address, a_cpu_read, a_cpu_write, a_cpu_master_cs, a_cpu_slave_cs;
  logic       a_cpu_waitrequest, a_pic_address, a_pic_read, a_pic_write, a_pic_master_cs, a_pic_slave_cs;
  logic [7:0] a_cpu_writedata, a_pic_writedata;
  logic       b_start, b_busy, b_done, b_cpu_address, b_cpu_read, b_cpu_write, b_cpu_master_cs, b_cpu_slave_cs;
  logic       b_cpu_waitrequest, b_pic_address, b_pic_read, b_pic_write, b_pic_master_cs, b_pic_slave_cs;
  logic [7:0] b_cpu_writedata, b_pic_writedata;
  logic       c_start, c_busy, c_done, c_cpu_address, c_cpu_read, c_cpu_write, c_cpu_master_cs, c_cpu_slave_cs;
  logic       c_cpu_waitrequest, c_pic_address, c_pic_read, c_pic_write, c_pic_master_cs, c_pic_slave_cs;
  logic [7:0] c_cpu_writedata, c_pic_writedata;

  logic [10:0] a_log[$], b_log[$], c_log[$];
  int          a_wc[$], b_wc[$], c_wc[$];
  int          a_dc[$], b_dc[$], c_dc[$];
  int          a_dones, b_dones, c_dones;

  pic_init_sequencer #(.GAP(1), .AUTO_START(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .cpu_address(a_cpu_address), .cpu_read(a_cpu_read), .cpu_write(a_cpu_write),
    .cpu_writedata(a_cpu_writedata), .cpu_master_cs(a_cpu_master_cs), .cpu_slave_cs(a_cpu_slave_cs),
    .cpu_waitrequest(a_cpu_waitrequest), .pic_address(a_pic_address), .pic_read(a_pic_read),
    .pic_write(a_pic_write), .pic_writedata(a_pic_writedata), .pic_master_cs(a_pic_master_cs),
    .pic_slave_cs(a_pic_slave_cs));

  pic_init_sequencer #(.GAP(1), .AUTO_START(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .cpu_address(b_cpu_address), .cpu_read(b_cpu_read), .cpu_write(b_cpu_write),
    .cpu_writedata(b_cpu_writedata), .cpu_master_cs(b_cpu_master_cs), .cpu_slave_cs(b_cpu_slave_cs),
    .cpu_waitrequest(b_cpu_waitrequest), .pic_address(b_pic_address), .pic_read(b_pic_read),
    .pic_write(b_pic_write), .pic_writedata(b_pic_writedata), .pic_master_cs(b_pic_master_cs),
    .pic_slave_cs(b_pic_slave_cs));

  pic_init_sequencer #(.GAP(0), .AUTO_START(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .busy(c_busy), .done(c_done),
    .cpu_address(c_cpu_address), .cpu_read(c_cpu_read), .cpu_write(c_cpu_write),
    .cpu_writedata(c_cpu_writedata), .cpu_master_cs(c_cpu_master_cs), .cpu_slave_cs(c_cpu_slave_cs),
    .cpu_waitrequest(c_cpu_waitrequest), .pic_address(c_pic_address), .pic_read(c_pic_read),
    .pic_write(c_pic_write), .pic_writedata(c_pic_writedata), .pic_master_cs(c_pic_master_cs),
    .pic_slave_cs(c_pic_slave_cs));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitors: log every PIC write as {addr, master_cs, slave_cs, data} with its cycle number.
  always @(negedge clk) begin
    if (a_pic_write) begin a_log.push_back({a_pic_address, a_pic_master_cs, a_pic_slave_cs, a_pic_writedata}); a_wc.push_back(cyc); end
    if (b_pic_write) begin b_log.push_back({b_pic_address, b_pic_master_cs, b_pic_slave_cs, b_pic_writedata}); b_wc.push_back(cyc); end
    if (c_pic_write) begin c_log.push_back({c_pic_address, c_pic_master_cs, c_pic_slave_cs, c_pic_writedata}); c_wc.push_back(cyc); end
    if (a_done) begin a_dones++; a_dc.push_back(cyc); end
    if (b_done) begin b_dones++; b_dc.push_back(cyc); end
    if (c_done) begin c_dones++; c_dc.push_back(cyc); end
  end

  function automatic logic [10:0] exp_entry(input int i);
    logic [7:0] d;
    logic       a;
    logic       m;
    case (i)
      0: d = 8'h11;  1: d = 8'h08;  2: d = 8'h04;  3: d = 8'h01;  4: d = 8'hB8;
      5: d = 8'h11;  6: d = 8'h70;  7: d = 8'h02;  8: d = 8'h01;  9: d = 8'hBD;
      default: d = 8'h00;
    endcase
    a = !((i == 0) || (i == 5));
    m = (i < 5);
    return {a, m, !m, d};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_run(input string tag, input logic [10:0] q[$], input int c[$], input int base, input int step);
    for (int i = 0; i < 10; i++) begin
      if (base + i < q.size()) begin
        check_eq($sformatf("%s_e%0d", tag, i), 32'(q[base+i]), 32'(exp_entry(i)));
        if (i > 0) check_eq($sformatf("%s_sp%0d", tag, i), c[base+i] - c[base+i-1], step);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n0;
  int rd_drop;
  int k;

  initial begin
    n_tests = 0; n_fail = 0;
    a_dones = 0; b_dones = 0; c_dones = 0;
    rst_n = 1'b0;
    {a_start, a_cpu_address, a_cpu_read, a_cpu_write, a_cpu_master_cs, a_cpu_slave_cs} = '0;
    {b_start, b_cpu_address, b_cpu_read, b_cpu_write, b_cpu_master_cs, b_cpu_slave_cs} = '0;
    {c_start, c_cpu_address, c_cpu_read, c_cpu_write, c_cpu_master_cs, c_cpu_slave_cs} = '0;
    a_cpu_writedata = 8'h00; b_cpu_writedata = 8'h00; c_cpu_writedata = 8'h00;

    #1;
    check_eq("rst_busy", a_busy, 1'b0);
    check_eq("rst_done", a_done, 1'b0);
    check_eq("rst_wait", a_cpu_waitrequest, 1'b0);
    check_eq("rst_pic_write", a_pic_write, 1'b0);
    check_eq("rst_pic_mcs", a_pic_master_cs, 1'b0);
    a_cpu_read = 1'b1; a_cpu_master_cs = 1'b1; a_cpu_address = 1'b1;
    #1;
    check_eq("rst_pass_read", a_pic_read, 1'b1);
    check_eq("rst_pass_mcs", a_pic_master_cs, 1'b1);
    check_eq("rst_pass_addr", a_pic_address, 1'b1);
    a_cpu_read = 1'b0; a_cpu_master_cs = 1'b0; a_cpu_address = 1'b0;
    repeat (3) tick();

    // Test 1: auto start after reset release
    a_log.delete(); a_wc.delete(); a_dc.delete(); a_dones = 0;
    rst_n = 1'b1;
    for (k = 0; k < 80 && a_dones < 1; k++) tick();
    repeat (4) tick();
    check_eq("t1_count", a_log.size(), 10);
    check_run("t1", a_log, a_wc, 0, 2);
    if (a_log.size() == 10) begin
      check_eq("t1_mas_imr", a_log[4][7:0], 8'hB8);
      check_eq("t1_sla_imr", a_log[9][7:0], 8'hBD);
      check_eq("t1_mas_base", a_log[1][7:0], 8'h08);
    end
    check_eq("t1_dones", a_dones, 1);
    check_eq("t1_no_auto_b", b_log.size(), 0);

    // Test 2: start while CPU read is in flight
    b_log.delete(); b_wc.delete(); b_dc.delete(); b_dones = 0;
    b_start = 1'b1; b_cpu_read = 1'b1; b_cpu_slave_cs = 1'b1;
    tick();
    b_start = 1'b0;
    check_eq("t2_pass_read", b_pic_read, 1'b1);
    check_eq("t2_arb_busy", b_busy, 1'b0);
    check_eq("t2_arb_wait", b_cpu_waitrequest, 1'b0);
    tick();
    check_eq("t2_arb_busy2", b_busy, 1'b0);
    tick();
    check_eq("t2_arb_busy3", b_busy, 1'b0);
    b_cpu_read = 1'b0; b_cpu_slave_cs = 1'b0;
    rd_drop = cyc;
    for (k = 0; k < 80 && b_dones < 1; k++) tick();
    repeat (3) tick();
    check_eq("t2_count", b_log.size(), 10);
    if (b_wc.size() > 0) check_eq("t2_first_write_cyc", b_wc[0], rd_drop + 1);
    check_run("t2", b_log, b_wc, 0, 2);

    // Test 4: extra starts while busy merge into one rerun
    b_log.delete(); b_wc.delete(); b_dc.delete(); b_dones = 0;
    tick();
    n0 = cyc;
    b_start = 1'b1; tick(); b_start = 1'b0;
    repeat (4) tick();
    b_start = 1'b1; tick(); b_start = 1'b0;
    repeat (3) tick();
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (k = 0; k < 150 && b_dones < 2; k++) tick();
    repeat (6) tick();
    check_eq("t4_count", b_log.size(), 20);
    check_eq("t4_dones", b_dones, 2);
    if (b_dc.size() == 2) begin
      check_eq("t4_done0_cyc", b_dc[0], n0 + 22);
      check_eq("t4_done1_cyc", b_dc[1], n0 + 44);
    end
    check_run("t4a", b_log, b_wc, 0, 2);
    check_run("t4b", b_log, b_wc, 10, 2);

    // Test 3: CPU write stalled mid-sequence, passes once idle
    b_log.delete(); b_wc.delete(); b_dc.delete(); b_dones = 0;
    tick();
    n0 = cyc;
    b_start = 1'b1; tick(); b_start = 1'b0;
    repeat (5) tick();
    b_cpu_write = 1'b1; b_cpu_address = 1'b1; b_cpu_master_cs = 1'b1; b_cpu_writedata = 8'hFF;
    #1;
    check_eq("t3_stalled", b_cpu_waitrequest, 1'b1);
    for (k = 0; k < 60 && b_cpu_waitrequest; k++) tick();
    check_eq("t3_stall_end", b_cpu_waitrequest, 1'b0);
    check_eq("t3_release_cyc", cyc, n0 + 22);
    check_eq("t3_idle_busy", b_busy, 1'b0);
    tick();
    b_cpu_write = 1'b0; b_cpu_address = 1'b0; b_cpu_master_cs = 1'b0; b_cpu_writedata = 8'h00;
    tick();
    check_eq("t3_count", b_log.size(), 11);
    check_run("t3", b_log, b_wc, 0, 2);
    if (b_log.size() == 11) check_eq("t3_cpu_imr", 32'(b_log[10]), 32'({1'b1, 1'b1, 1'b0, 8'hFF}));

    // Test 5: reset mid-sequence aborts, auto start reruns from idx 0
    a_log.delete(); a_wc.delete(); a_dc.delete(); a_dones = 0;
    tick();
    n0 = cyc;
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (11) tick();
    check_eq("t5_pre_write", a_pic_write, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_abort_write", a_pic_write, 1'b0);
    check_eq("t5_abort_busy", a_busy, 1'b0);
    check_eq("t5_partial_count", a_log.size(), 5);
    if (a_log.size() == 5) check_eq("t5_last_partial", 32'(a_log[4]), 32'(exp_entry(4)));
    a_log.delete(); a_wc.delete(); a_dc.delete(); a_dones = 0;
    tick(); tick();
    rst_n = 1'b1;
    for (k = 0; k < 80 && a_dones < 1; k++) tick();
    repeat (3) tick();
    check_eq("t5_count", a_log.size(), 10);
    check_run("t5", a_log, a_wc, 0, 2);

    // Test 6: GAP=0 back-to-back writes
    c_log.delete(); c_wc.delete(); c_dc.delete(); c_dones = 0;
    tick();
    n0 = cyc;
    c_start = 1'b1; tick(); c_start = 1'b0;
    for (k = 0; k < 40 && c_dones < 1; k++) tick();
    repeat (3) tick();
    check_eq("t6_count", c_log.size(), 10);
    check_run("t6", c_log, c_wc, 0, 1);
    if (c_wc.size() == 10) check_eq("t6_first_cyc", c_wc[0], n0 + 2);
    check_eq("t6_dones", c_dones, 1);
    if (c_dc.size() == 1 && c_wc.size() == 10) check_eq("t6_done_cyc", c_dc[0], c_wc[9] + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
